banked_shared_memory: RTL and testbench

Parametrised multi-port shared memory for the accelerator: NUM_PORTS requesters (compute units, vector loader, matrix loader) access one word-addressed store split into NUM_BANKS low-order-interleaved banks. Each bank has a round-robin arbiter, so requests to different banks proceed in parallel and same-bank requests serialise. Every accepted request gets a registered response (read data, write-through data, or range error) one cycle later. This block replaces the fixed two-port vector/matrix memory with a generalised, contention-aware store.

---
 rtl/banked_shared_memory.sv | 173 +++++++++++++++++
 tb/tb_banked_shared_memory.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_shared_memory.sv
// banked_shared_memory: multi-port word-addressed store split into
// low-order-interleaved banks. Each bank runs its own round-robin arbiter, so
// requests to different banks proceed in parallel and same-bank requests
// serialise. Accepted requests get a registered response one cycle later.
module banked_shared_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
    output logic [NUM_PORTS-1:0]             rsp_error,
    output logic [15:0]                      conflict_count,
    output logic                             busy
);

    localparam int BANK_SHIFT = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int ROWS       = DEPTH / NUM_BANKS;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ADDR_WIDTH-1:0] port_addr_s  [NUM_PORTS];
    logic [BANK_W-1:0]     port_bank_s  [NUM_PORTS];
    logic [ROW_W-1:0]      port_row_s   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_range_s;
    logic [NUM_PORTS-1:0]  port_gnt_s;
    logic [NUM_PORTS-1:0]  ready_s;

    logic [PORT_W-1:0]     ptr_r        [NUM_BANKS];
    logic [NUM_BANKS-1:0]  bank_gnt_s;
    logic [NUM_BANKS-1:0]  bank_we_s;
    logic [PORT_W-1:0]     bank_port_s  [NUM_BANKS];
    logic [ROW_W-1:0]      bank_row_s   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata_s [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];

    // Storage is intentionally not reset; only the control path is.
    logic [DATA_WIDTH-1:0] mem_r [NUM_BANKS][ROWS];

    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_nxt_s;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_r;
    logic [NUM_PORTS-1:0]            rsp_valid_r;
    logic [NUM_PORTS-1:0]            rsp_error_r;
    logic [15:0]                     conflict_count_r;
    logic                            busy_r;

    // Split each port's address into range flag, bank index and bank row.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_addr_s[p] = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            in_range_s[p]  = ({1'b0, port_addr_s[p]} < (ADDR_WIDTH+1)'(DEPTH));
            port_bank_s[p] = (NUM_BANKS > 1) ? BANK_W'(port_addr_s[p]) : {BANK_W{1'b0}};
            port_row_s[p]  = ROW_W'(port_addr_s[p] >> BANK_SHIFT);
        end
    end

    // Per-bank round-robin: first in-range requester at or after the pointer wins.
    always_comb begin : arb
        int idx;
        idx = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_gnt_s[b]  = 1'b0;
            bank_port_s[b] = {PORT_W{1'b0}};
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(ptr_r[b]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end else begin
                    idx = idx;
                end
                if (!rst && !bank_gnt_s[b] && req_valid[idx] && in_range_s[idx] &&
                    (int'(port_bank_s[idx]) == b)) begin
                    bank_gnt_s[b]  = 1'b1;
                    bank_port_s[b] = PORT_W'(idx);
                end else begin
                    bank_gnt_s[b]  = bank_gnt_s[b];
                end
            end
        end
    end

    // Route the winning port's request onto each bank's single access port.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we_s[b]    = bank_gnt_s[b] & req_we[bank_port_s[b]];
            bank_row_s[b]   = port_row_s[bank_port_s[b]];
            bank_wdata_s[b] = req_wdata[int'(bank_port_s[b])*DATA_WIDTH +: DATA_WIDTH];
            bank_rdata_s[b] = mem_r[b][bank_row_s[b]];
        end
    end

    // Per-port acceptance and next response data; out-of-range requests bypass arbitration.
    always_comb begin
        rsp_rdata_nxt_s = {(NUM_PORTS*DATA_WIDTH){1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_gnt_s[p] = 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_gnt_s[b] && (int'(bank_port_s[b]) == p)) begin
                    port_gnt_s[p] = 1'b1;
                end else begin
                    port_gnt_s[p] = port_gnt_s[p];
                end
            end
            ready_s[p] = !rst && req_valid[p] && (in_range_s[p] ? port_gnt_s[p] : 1'b1);
            if (ready_s[p] && in_range_s[p]) begin
                rsp_rdata_nxt_s[p*DATA_WIDTH +: DATA_WIDTH] =
                    req_we[p] ? req_wdata[p*DATA_WIDTH +: DATA_WIDTH]
                              : bank_rdata_s[port_bank_s[p]];
            end else begin
                rsp_rdata_nxt_s[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Bank write ports; a grant never happens while rst is high.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_we_s[b]) begin
                mem_r[b][bank_row_s[b]] <= bank_wdata_s[b];
            end
        end
    end

    // Control state: responses, arbiter pointers, conflict counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r      <= {NUM_PORTS{1'b0}};
            rsp_error_r      <= {NUM_PORTS{1'b0}};
            rsp_rdata_r      <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
            conflict_count_r <= 16'h0000;
            busy_r           <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_r[b] <= {PORT_W{1'b0}};
            end
        end else begin
            rsp_valid_r <= ready_s;
            rsp_error_r <= ready_s & ~in_range_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            busy_r      <= |ready_s;
            if (|(req_valid & ~ready_s) && (conflict_count_r != 16'hFFFF)) begin
                conflict_count_r <= conflict_count_r + 16'd1;
            end else begin
                conflict_count_r <= conflict_count_r;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_gnt_s[b]) begin
                    ptr_r[b] <= (int'(bank_port_s[b]) == NUM_PORTS - 1) ? {PORT_W{1'b0}}
                                                                       : bank_port_s[b] + PORT_W'(1);
                end else begin
                    ptr_r[b] <= ptr_r[b];
                end
            end
        end
    end

    assign req_ready      = ready_s;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_error      = rsp_error_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign conflict_count = conflict_count_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_banked_shared_memory.sv
// Testbench for banked_shared_memory: directed steps plus random traffic,
// checked against an address-indexed reference model of the shared store.
module tb_banked_shared_memory;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 7;
    localparam int NP    = 4;
    localparam int NB    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_error;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_rdata;
    logic [15:0]      conflict_count;
    logic             busy;

    banked_shared_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                           .NUM_PORTS(NP), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .conflict_count(conflict_count), .busy(busy));

    always #5 clk = ~clk;

    // Reference model: flat address-indexed store, one priority pointer per bank.
    logic [DW-1:0] mem_m [DEPTH];
    int            ptr_m [NB];
    int            cnt_m;
    logic          busy_m;
    logic [NP-1:0] acc_m;
    logic [NP-1:0] err_m;
    logic [DW-1:0] dat_m [NP];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int addr_of(int p);
        return int'(req_addr[p*AW +: AW]);
    endfunction

    task automatic set_req(int p, logic we, int a, logic [DW-1:0] d);
        req_valid[p]            = 1'b1;
        req_we[p]               = we;
        req_addr[p*AW +: AW]    = AW'(a);
        req_wdata[p*DW +: DW]   = d;
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        cnt_m  = 0;
        busy_m = 1'b0;
    endtask

    // A port is accepted if out of range, or if it is the closest requester
    // (circular distance from the bank pointer) among those to its bank.
    task automatic model_grants();
        acc_m = '0;
        for (int p = 0; p < NP; p++) begin
            if (req_valid[p]) begin
                if (addr_of(p) >= DEPTH) begin
                    acc_m[p] = 1'b1;
                end else begin
                    int bk;
                    int dp;
                    logic best;
                    bk   = addr_of(p) % NB;
                    dp   = (p - ptr_m[bk] + NP) % NP;
                    best = 1'b1;
                    for (int q = 0; q < NP; q++) begin
                        if (req_valid[q] && addr_of(q) < DEPTH && addr_of(q) % NB == bk &&
                            (q - ptr_m[bk] + NP) % NP < dp) best = 1'b0;
                    end
                    acc_m[p] = best;
                end
            end
        end
    endtask

    // One clock of traffic: check grants, advance the model, check responses.
    task automatic step();
        logic stall;
        #2;
        model_grants();
        check("req_ready", req_ready, acc_m);
        stall = |(req_valid & ~acc_m);
        for (int p = 0; p < NP; p++) begin
            err_m[p] = acc_m[p] && addr_of(p) >= DEPTH;
            if (!acc_m[p] || err_m[p]) dat_m[p] = '0;
            else if (req_we[p])        dat_m[p] = req_wdata[p*DW +: DW];
            else                       dat_m[p] = mem_m[addr_of(p)];
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (acc_m[p] && !err_m[p]) begin
                ptr_m[addr_of(p) % NB] = (p + 1) % NP;
                if (req_we[p]) mem_m[addr_of(p)] = req_wdata[p*DW +: DW];
            end
        end
        if (stall) cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
        busy_m = |acc_m;
        #1;
        check("rsp_valid", rsp_valid, acc_m);
        for (int p = 0; p < NP; p++) begin
            if (acc_m[p]) begin
                check($sformatf("rsp_error[%0d]", p), rsp_error[p], err_m[p]);
                check($sformatf("rsp_rdata[%0d]", p), rsp_rdata[p*DW +: DW], dat_m[p]);
            end
        end
        check("busy", busy, busy_m);
        check("conflict_count", conflict_count, cnt_m);
    endtask

    // Step until every pending request is accepted, within a cycle budget.
    task automatic run_all(int max_cycles);
        int n;
        n = 0;
        while (req_valid != '0 && n < max_cycles) begin
            step();
            req_valid = req_valid & ~acc_m;
            n++;
        end
        check("drain_within_budget", req_valid, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        model_reset();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 8, 32'h100 + DW'(p));
        #2;
        check("reset_req_ready", req_ready, '0);
        check("reset_rsp_valid", rsp_valid, '0);
        check("reset_rsp_rdata", rsp_rdata[63:0], 64'h0);
        check("reset_rsp_error", rsp_error, '0);
        check("reset_conflict", conflict_count, 16'h0);
        check("reset_busy", busy, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Release: port 0 must win bank 0 first.
        #2;
        check("reset_release_winner", req_ready, 4'b0001);
        run_all(10);

        // Fill every word so later reads are well defined (one bank per port).
        for (int i = 0; i < DEPTH / NP; i++) begin
            for (int p = 0; p < NP; p++) set_req(p, 1'b1, i*NP + p, $urandom);
            run_all(4);
        end

        // Parallel banks: four writes then four reads in single cycles.
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, p, 32'hA0 + DW'(p));
        #2;
        check("parallel_write_ready", req_ready, 4'b1111);
        run_all(4);
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, p, '0);
        run_all(4);
        check("parallel_read_p2", rsp_rdata[2*DW +: DW], 32'hA2);

        // Contention: four readers on address 8 serialise.
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 8, '0);
        run_all(8);

        // Range error alongside a bank-2 access.
        set_req(0, 1'b0, 2, '0);
        set_req(2, 1'b1, 70, 32'hBEEF);
        #2;
        check("range_ready", req_ready, 4'b0101);
        run_all(4);
        check("range_error_p2", rsp_error[2], 1'b1);
        check("range_rdata_p2", rsp_rdata[2*DW +: DW], 32'h0);
        set_req(1, 1'b0, 70, '0);
        run_all(4);

        // Random traffic with held requests.
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_valid[p] && $urandom_range(0, 9) < 6)
                    set_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 71), $urandom);
            end
            step();
            req_valid = req_valid & ~acc_m;
        end
        req_valid = '0;
        step();

        // Saturation: two ports fight over bank 0 every cycle.
        set_req(0, 1'b0, 12, '0);
        set_req(1, 1'b0, 12, '0);
        for (int c = 0; c < 70000; c++) step();
        check("conflict_saturated", conflict_count, 16'hFFFF);

        // Reset mid-operation, with a write presented while reset is held.
        set_req(0, 1'b1, 20, 32'hDEAD);
        set_req(2, 1'b0, 22, '0);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_ready", req_ready, '0);
        check("midreset_rsp_valid", rsp_valid, '0);
        check("midreset_conflict", conflict_count, 16'h0);
        check("midreset_busy", busy, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        step();
        set_req(3, 1'b0, 20, '0);
        run_all(4);

        // Write/read race on address 5 with fresh pointers.
        set_req(1, 1'b1, 5, 32'h55);
        set_req(3, 1'b0, 5, '0);
        run_all(6);
        check("race_p3_valid", rsp_valid[3], 1'b1);
        check("race_p3_rdata", rsp_rdata[3*DW +: DW], 32'h55);

        // Short random tail after reset.
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_valid[p] && $urandom_range(0, 9) < 7)
                    set_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 71), $urandom);
            end
            step();
            req_valid = req_valid & ~acc_m;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
